// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer: FSM state encoding and small helpers.
package round_timer_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Low-time window: strictly positive and at or below the threshold.
   function automatic logic in_warn_window(input int unsigned secs, input int unsigned warn);
      return (secs != 32'd0) && (secs <= warn);
   endfunction

endpackage

// File: rtl/round_timer_tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and flags the wrap cycle.
module round_timer_tick_prescaler #(
   parameter int DIV = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Clear wins over counting, so a restart never produces a stray wrap.
   assign wrap = en && !clr && (count == LAST);

   // Divider counter: cleared on request, held while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/round_timer.sv
// Countdown round timer: programmable preset, pause/resume, restart, warning and end pulse.
module round_timer
   import round_timer_pkg::*;
#(
   parameter int CLK_HZ       = 1_000_000,
   parameter int TICK_HZ      = 1,
   parameter int SECS_W       = 7,
   parameter int DEFAULT_SECS = 30,
   parameter int WARN_SECS    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              pause,
   input  logic              load_en,
   input  logic [SECS_W-1:0] load_secs,
   output logic [SECS_W-1:0] secs_left,
   output logic              tick,
   output logic              running,
   output logic              warning,
   output logic              game_end,
   output logic              game_end_pulse
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam logic [SECS_W-1:0] DEF_SECS = SECS_W'(DEFAULT_SECS);

   state_t            state;
   state_t            state_nx;
   logic [SECS_W-1:0] preset;
   logic [SECS_W-1:0] preset_nx;
   logic [SECS_W-1:0] secs;
   logic [SECS_W-1:0] secs_nx;
   logic              tick_q;
   logic              tick_nx;
   logic              pulse_q;
   logic              pulse_nx;
   logic              pre_en;
   logic              pre_clr;
   logic              wrap;
   logic              idle_like;
   logic [SECS_W-1:0] load_val;

   // A zero-length round is meaningless, so a zero preset becomes one second.
   assign load_val  = (load_secs == '0) ? SECS_W'(1) : load_secs;
   assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

   // The prescaler advances whenever a round is live and not held; a paused
   // round being released counts on the release edge itself.
   assign pre_en  = ena && ((state == ST_RUN) || (state == ST_PAUSED)) && !pause;
   assign pre_clr = ena && start;

   round_timer_tick_prescaler #(
      .DIV (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pre_en),
      .clr   (pre_clr),
      .wrap  (wrap)
   );

   // Next-state, preset, seconds counter and pulse decisions.
   always_comb begin
      state_nx  = state;
      preset_nx = preset;
      secs_nx   = secs;
      tick_nx   = 1'b0;
      pulse_nx  = 1'b0;
      if (!ena) begin
         state_nx = state;
      end else begin
         if (idle_like && load_en) begin
            preset_nx = load_val;
         end else begin
            preset_nx = preset;
         end
         if (start) begin
            // Restart beats a same-cycle tick; a same-cycle load is honoured.
            secs_nx  = (idle_like && load_en) ? load_val : preset;
            state_nx = pause ? ST_PAUSED : ST_RUN;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (load_en) begin
                     secs_nx = load_val;
                  end else begin
                     secs_nx = secs;
                  end
               end
               ST_RUN, ST_PAUSED: begin
                  if (pause) begin
                     state_nx = ST_PAUSED;
                  end else if (wrap) begin
                     tick_nx = 1'b1;
                     if (secs <= SECS_W'(1)) begin
                        secs_nx  = '0;
                        state_nx = ST_DONE;
                        pulse_nx = 1'b1;
                     end else begin
                        secs_nx  = secs - SECS_W'(1);
                        state_nx = ST_RUN;
                     end
                  end else begin
                     state_nx = ST_RUN;
                  end
               end
               ST_DONE: begin
                  state_nx = ST_DONE;
               end
               default: begin
                  state_nx = ST_IDLE;
               end
            endcase
         end
      end
   end

   // State, preset, counter and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         preset  <= DEF_SECS;
         secs    <= DEF_SECS;
         tick_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state   <= state_nx;
         preset  <= preset_nx;
         secs    <= secs_nx;
         tick_q  <= tick_nx;
         pulse_q <= pulse_nx;
      end
   end

   assign secs_left      = secs;
   assign running        = (state == ST_RUN);
   assign game_end       = (state == ST_DONE);
   assign tick           = tick_q & ena;
   assign game_end_pulse = pulse_q & ena;
   assign warning        = in_warn_window(32'(secs), 32'(WARN_SECS));

endmodule

// File: tb/tb_round_timer.sv
// Randomised and directed bench for round_timer with a scoreboard and a cycle-budget model.
module tb_round_timer;

   localparam int P    = 8;
   localparam int DEF  = 3;
   localparam int WARN = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       load_en = 1'b0;
   logic [6:0] load_secs = 7'd0;
   logic [6:0] secs_left;
   logic       tick, running, warning, game_end, game_end_pulse;

   round_timer #(
      .CLK_HZ(8), .TICK_HZ(1), .SECS_W(7), .DEFAULT_SECS(DEF), .WARN_SECS(WARN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .pause(pause),
      .load_en(load_en), .load_secs(load_secs), .secs_left(secs_left), .tick(tick),
      .running(running), .warning(warning), .game_end(game_end),
      .game_end_pulse(game_end_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] secs;
      logic       tick;
      logic       running;
      logic       warning;
      logic       game_end;
      logic       pulse;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Reference model: a round is a budget of clock cycles still to be counted.
   int   m_mode;      // 0 idle, 1 run, 2 paused, 3 done
   int   m_preset;
   int   m_left;
   bit   m_tick;
   bit   m_pulse;
   int   since_start = 0;
   bit   last_pulse = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
   endtask

   task automatic model_reset();
      m_mode = 0; m_preset = DEF; m_left = DEF * P; m_tick = 0; m_pulse = 0;
   endtask

   task automatic model_edge(input bit s, input bit pa, input bit le, input int ls, input bit en);
      int ld;
      bit idle_like;
      m_tick = 0;
      m_pulse = 0;
      if (!en) return;
      ld = (ls == 0) ? 1 : ls;
      idle_like = (m_mode == 0) || (m_mode == 3);
      if (idle_like && le) m_preset = ld;
      if (s) begin
         m_left = m_preset * P;
         m_mode = pa ? 2 : 1;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (pa) m_mode = 2;
         else begin
            m_left--;
            m_tick = (m_left % P) == 0;
            if (m_left == 0) begin m_mode = 3; m_pulse = 1; end
            else m_mode = 1;
         end
      end else if (m_mode == 0 && le) begin
         m_left = m_preset * P;
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int s;
      s = (m_left + P - 1) / P;
      e.secs     = 7'(s);
      e.tick     = m_tick;
      e.running  = (m_mode == 1);
      e.warning  = (s != 0) && (s <= WARN);
      e.game_end = (m_mode == 3);
      e.pulse    = m_pulse;
      return e;
   endfunction

   // Monitor: after every active edge compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            got = {secs_left, tick, running, warning, game_end, game_end_pulse};
            check("cycle{secs,tick,run,warn,end,pulse}", int'(got), int'(e));
         end
      end
   end

   // One clock of stimulus: drive at negedge, queue the expectation, return after the edge.
   task automatic step(input bit s, input bit pa, input bit le, input logic [6:0] ls, input bit en);
      @(negedge clk);
      start = s; pause = pa; load_en = le; load_secs = ls; ena = en;
      model_edge(s, pa, le, int'(ls), en);
      q.push_back(model_out());
      if (en && s) since_start = 0;
      else since_start++;
      @(posedge clk);
      #2;
      last_pulse = game_end_pulse;
   endtask

   task automatic cyc(input int n, input bit pa, input bit en);
      for (int i = 0; i < n; i++) step(1'b0, pa, 1'b0, 7'd0, en);
   endtask

   // Step until the end pulse and check how many cycles the round took.
   task automatic wait_end(input string name, input int req);
      int guard;
      guard = 0;
      last_pulse = 1'b0;
      while (!last_pulse && guard < 2000) begin
         step(1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
         guard++;
      end
      if (!last_pulse) check({name, "_timeout"}, 0, 1);
      else check(name, since_start, req);
   endtask

   initial begin
      bit rp;
      model_reset();
      #23;
      rst_n = 1'b1;
      ena = 1'b1;
      #1;
      check("reset_secs", int'(secs_left), DEF);
      check("reset_flags", int'({tick, running, warning, game_end, game_end_pulse}), 0);

      // Basic round from the default preset.
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      check("t1_running", int'(running), 1);
      wait_end("t1_len", 24);
      check("t1_game_end", int'(game_end), 1);

      // Programmed preset and the zero clamp.
      step(1'b0, 1'b0, 1'b1, 7'd5, 1'b1);
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      wait_end("t2_len5", 40);
      step(1'b0, 1'b0, 1'b1, 7'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      wait_end("t2_len_clamp", 8);

      // Pause for 20 cycles four cycles into a 3-second round.
      step(1'b0, 1'b0, 1'b1, 7'd3, 1'b1);
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      cyc(3, 1'b0, 1'b1);
      cyc(20, 1'b1, 1'b1);
      wait_end("t3_len_paused", 44);

      // Restart mid-round; also a start that loads in the same cycle.
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      cyc(11, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      check("t4_secs_after_restart", int'(secs_left), 3);
      wait_end("t4_len_restart", 24);
      step(1'b1, 1'b0, 1'b1, 7'd2, 1'b1);
      wait_end("t4_len_load_start", 16);

      // Load ignored mid-round, ena low stretches the round.
      step(1'b0, 1'b0, 1'b1, 7'd3, 1'b1);
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      cyc(4, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 7'd7, 1'b1);
      check("t5_load_ignored", int'(secs_left), 3);
      cyc(10, 1'b0, 1'b0);
      wait_end("t5_len_ena", 34);

      // Asynchronous reset mid-round.
      step(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
      cyc(20, 1'b0, 1'b1);
      #1;
      rst_n = 1'b0;
      q.delete();
      model_reset();
      #1;
      check("t6_reset_secs", int'(secs_left), DEF);
      check("t6_reset_flags", int'({tick, running, warning, game_end, game_end_pulse}), 0);
      cyc(3, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(4, 1'b0, 1'b1);
      check("t6_no_pulse", int'(last_pulse), 0);

      // Warning follows a 1-second preset in IDLE.
      step(1'b0, 1'b0, 1'b1, 7'd1, 1'b1);
      check("t6_warn_idle", int'(warning), 1);

      // Randomised traffic against the model.
      rp = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) rp = ~rp;
         step(($urandom_range(0, 39) == 0), rp, ($urandom_range(0, 19) == 0),
              7'($urandom_range(0, 6)), ($urandom_range(0, 9) != 0));
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
